imm_gen_pipe: RTL and testbench

Registered, handshaked immediate generator for the decode stage. It extracts and sign-extends I/S/B (and optionally U/J) immediates to a parametrised XLEN. Results are held in a 2-entry elastic buffer so that decode-to-execute backpressure does not require re-presenting the instruction. A sideband tag (e.g. PC or ROB index) travels with each immediate. Illegal format selects are flagged per entry and counted.

---
 rtl/imm_gen_pipe.sv | 129 ++++++++++++
 tb/tb_imm_gen_pipe.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decode-stage immediate generator with a 2-entry elastic
// output buffer. Extracts I/S/B (and U/J when IMM_GEN_UJ_EN is defined)
// immediates, sign-extends them to XLEN, and carries a sideband tag and an
// illegal-select flag per entry. Illegal selects accepted into the buffer
// are counted in a saturating counter that only reset clears.
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    logic [31:0]      raw;
    logic [XLEN-1:0]  imm_d;
    logic             ill_d;

    logic [XLEN-1:0]  imm_q [2];
    logic [TAG_W-1:0] tag_q [2];
    logic [1:0]       ill_q;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [CNT_W-1:0] cnt_q;

    logic             push;
    logic             pop;
    logic             unused_bits;

    // Opcode bits never feed an immediate; U/J-only bits are idle without the macro.
    assign unused_bits = ^{in_instr[19:12], in_instr[6:0]};

    // Combinational format extraction and sign extension from instr[31].
    always_comb begin
        raw   = '0;
        ill_d = 1'b0;
        case (in_sel)
            3'b000: raw = {{20{in_instr[31]}}, in_instr[31:20]};
            3'b001: raw = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            3'b010: raw = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
`ifdef IMM_GEN_UJ_EN
            3'b011: raw = {in_instr[31:12], 12'b0};
            3'b100: raw = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
`else
            3'b011, 3'b100: begin
                raw   = '0;
                ill_d = 1'b1;
            end
`endif
            default: begin
                raw   = '0;
                ill_d = 1'b1;
            end
        endcase
        imm_d       = {XLEN{raw[31]}};
        imm_d[31:0] = raw;
    end

    assign in_ready = rst_n && (count != 2'd2) && !flush;
    assign push     = in_valid && in_ready;
    assign pop      = (count != 2'd0) && out_ready;

    // Entry storage: written at the write pointer on every accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                imm_q[i] <= '0;
                tag_q[i] <= '0;
            end
            ill_q <= '0;
        end else if (push) begin
            imm_q[wr_ptr] <= imm_d;
            tag_q[wr_ptr] <= in_tag;
            ill_q[wr_ptr] <= ill_d;
        end
    end

    // Pointer and occupancy control; flush empties the buffer and drops pops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Saturating count of accepted illegal selects; survives flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (push && ill_d && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign out_valid   = (count != 2'd0);
    assign out_imm     = out_valid ? imm_q[rd_ptr] : '0;
    assign out_tag     = out_valid ? tag_q[rd_ptr] : '0;
    assign out_illegal = out_valid ? ill_q[rd_ptr] : 1'b0;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_imm_gen_pipe;

    localparam int XLEN    = 32;
    localparam int TAG_W   = 8;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [31:0]      in_instr = '0;
    logic [2:0]       in_sel = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             in_ready;
    logic             out_valid;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;
    logic [CNT_W-1:0] illegal_cnt;

    int n_cmp = 0;
    int n_err = 0;

    imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_tag(out_tag), .out_illegal(out_illegal),
        .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    // Reference: immediate value as a signed integer built from field weights.
    function automatic logic [XLEN-1:0] ref_imm(input logic [31:0] ins,
                                                input logic [2:0] sel,
                                                output logic ill);
        longint v;
        ill = 1'b0;
        v   = 0;
        case (sel)
            3'd0: v = longint'(ins[30:20]) - longint'(ins[31]) * 2048;
            3'd1: v = longint'(ins[30:25]) * 32 + longint'(ins[11:7])
                      - longint'(ins[31]) * 2048;
            3'd2: v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
                      + longint'(ins[11:8]) * 2 - longint'(ins[31]) * 4096;
`ifdef IMM_GEN_UJ_EN
            3'd3: v = longint'(ins[30:12]) * 4096 - longint'(ins[31]) * 64'sh8000_0000;
            3'd4: v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
                      + longint'(ins[30:21]) * 2 - longint'(ins[31]) * 1048576;
`endif
            default: begin
                v   = 0;
                ill = 1'b1;
            end
        endcase
        return v[XLEN-1:0];
    endfunction

    typedef struct {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             ill;
    } ent_t;

    ent_t mq[$];
    int   mcnt = 0;
    bit   m_rdy, m_push, m_pop;
    logic m_ill;
    ent_t m_ent;

    // Reference model of the buffer and counter.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mcnt = 0;
        end else begin
            m_rdy  = (mq.size() < 2) && !flush;
            m_push = in_valid && m_rdy;
            m_pop  = (mq.size() != 0) && out_ready;
            if (flush) begin
                mq.delete();
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_push) begin
                    m_ent.imm = ref_imm(in_instr, in_sel, m_ill);
                    m_ent.tag = in_tag;
                    m_ent.ill = m_ill;
                    mq.push_back(m_ent);
                    if (m_ill && mcnt < CNT_MAX) mcnt++;
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] ins,
                         input logic [2:0] sel, input logic [TAG_W-1:0] tag);
        in_valid = v;
        in_instr = ins;
        in_sel   = sel;
        in_tag   = tag;
    endtask

    task automatic test_reset;
        #2;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        n_cmp++; if (out_imm !== '0) begin n_err++; $display("FAIL rst_out_imm got=%h exp=0", out_imm); end
        n_cmp++; if (out_tag !== '0) begin n_err++; $display("FAIL rst_out_tag got=%h exp=0", out_tag); end
        n_cmp++; if (out_illegal !== 1'b0) begin n_err++; $display("FAIL rst_out_illegal got=%b exp=0", out_illegal); end
        n_cmp++; if (illegal_cnt !== '0) begin n_err++; $display("FAIL rst_illegal_cnt got=%0d exp=0", illegal_cnt); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_i_format;
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive(1'b1, 32'hFFF0_0093, 3'b000, 8'h11);
        @(posedge clk); #1;
        drive(1'b0, '0, '0, '0);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL i_valid got=%b exp=1", out_valid); end
        n_cmp++; if (out_imm !== {XLEN{1'b1}}) begin n_err++; $display("FAIL i_imm got=%h exp=all-ones", out_imm); end
        n_cmp++; if (out_tag !== 8'h11) begin n_err++; $display("FAIL i_tag got=%h exp=11", out_tag); end
        n_cmp++; if (out_illegal !== 1'b0) begin n_err++; $display("FAIL i_illegal got=%b exp=0", out_illegal); end
    endtask

    task automatic test_back_to_back;
        @(posedge clk); #1;
        drive(1'b1, 32'hFE20_AE23, 3'b001, 8'h21);
        @(posedge clk); #1;
        drive(1'b1, 32'h0000_0463, 3'b010, 8'h22);
        @(negedge clk);
        n_cmp++; if (out_imm !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL s_imm got=%h exp=fffffffc", out_imm); end
        n_cmp++; if (out_tag !== 8'h21) begin n_err++; $display("FAIL s_tag got=%h exp=21", out_tag); end
        @(posedge clk); #1;
        drive(1'b0, '0, '0, '0);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b_valid got=%b exp=1", out_valid); end
        n_cmp++; if (out_imm !== 32'h0000_0008) begin n_err++; $display("FAIL b_imm got=%h exp=00000008", out_imm); end
        n_cmp++; if (out_tag !== 8'h22) begin n_err++; $display("FAIL b_tag got=%h exp=22", out_tag); end
    endtask

    task automatic test_u_format;
        @(posedge clk); #1;
        drive(1'b1, 32'h1234_50B7, 3'b011, 8'h31);
        @(posedge clk); #1;
        drive(1'b0, '0, '0, '0);
        @(negedge clk);
`ifdef IMM_GEN_UJ_EN
        n_cmp++; if (out_imm !== 32'h1234_5000) begin n_err++; $display("FAIL u_imm got=%h exp=12345000", out_imm); end
        n_cmp++; if (out_illegal !== 1'b0) begin n_err++; $display("FAIL u_illegal got=%b exp=0", out_illegal); end
        n_cmp++; if (illegal_cnt !== 8'd0) begin n_err++; $display("FAIL u_cnt got=%0d exp=0", illegal_cnt); end
`else
        n_cmp++; if (out_imm !== '0) begin n_err++; $display("FAIL u_imm got=%h exp=0", out_imm); end
        n_cmp++; if (out_illegal !== 1'b1) begin n_err++; $display("FAIL u_illegal got=%b exp=1", out_illegal); end
        n_cmp++; if (illegal_cnt !== 8'd1) begin n_err++; $display("FAIL u_cnt got=%0d exp=1", illegal_cnt); end
`endif
    endtask

    task automatic test_backpressure;
        logic [TAG_W-1:0] tags [3];
        logic [TAG_W-1:0] got[$];
        bit acc;
        tags = '{8'hA0, 8'hB1, 8'hC2};
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(1'b1, $urandom, 3'b000, tags[0]);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_%0d got=%b exp=1", c, in_ready); end
            @(posedge clk); #1;
            drive(1'b1, $urandom, 3'b000, tags[c+1]);
        end
        for (int h = 0; h < 2; h++) begin
            @(negedge clk);
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready got=%b exp=0", in_ready); end
            n_cmp++; if (out_tag !== tags[0]) begin n_err++; $display("FAIL bp_hold_tag got=%h exp=%h", out_tag, tags[0]); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int c = 0; c < 12 && got.size() < 3; c++) begin
            @(negedge clk);
            if (out_valid) got.push_back(out_tag);
            acc = in_ready && in_valid;
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
        end
        n_cmp++; if (got.size() != 3) begin n_err++; $display("FAIL bp_drain_count got=%0d exp=3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            n_cmp++; if (got[i] !== tags[i]) begin n_err++; $display("FAIL bp_order_%0d got=%h exp=%h", i, got[i], tags[i]); end
        end
        n_cmp++; if (in_valid !== 1'b0) begin n_err++; $display("FAIL bp_third_accepted got=%b exp=0", in_valid); end
        drive(1'b0, '0, '0, '0);
    endtask

    task automatic test_flush;
        int cnt_before;
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(1'b1, $urandom, 3'b111, 8'h41);
        @(posedge clk); #1;
        drive(1'b1, $urandom, 3'b000, 8'h42);
        @(posedge clk); #1;
        drive(1'b0, '0, '0, '0);
        @(negedge clk);
        cnt_before = mcnt;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL fl_pre_valid got=%b exp=1", out_valid); end
        @(posedge clk); #1;
        flush = 1'b1;
        drive(1'b1, $urandom, 3'b111, 8'h43);
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fl_in_ready got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        flush = 1'b0;
        drive(1'b0, '0, '0, '0);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fl_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (out_imm !== '0) begin n_err++; $display("FAIL fl_out_imm got=%h exp=0", out_imm); end
        n_cmp++; if (illegal_cnt !== CNT_W'(cnt_before)) begin n_err++; $display("FAIL fl_cnt got=%0d exp=%0d", illegal_cnt, cnt_before); end
    endtask

    task automatic test_random;
        logic [XLEN-1:0]  e_imm;
        logic [TAG_W-1:0] e_tag;
        logic             e_ill;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            e_imm = '0; e_tag = '0; e_ill = 1'b0;
            if (mq.size() != 0) begin
                e_imm = mq[0].imm; e_tag = mq[0].tag; e_ill = mq[0].ill;
            end
            n_cmp++; if (out_valid !== (mq.size() != 0)) begin n_err++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid, mq.size() != 0); end
            n_cmp++; if (in_ready !== ((mq.size() < 2) && !flush)) begin n_err++; $display("FAIL rnd_ready c=%0d got=%b", c, in_ready); end
            n_cmp++; if (out_imm !== e_imm) begin n_err++; $display("FAIL rnd_imm c=%0d got=%h exp=%h", c, out_imm, e_imm); end
            n_cmp++; if (out_tag !== e_tag) begin n_err++; $display("FAIL rnd_tag c=%0d got=%h exp=%h", c, out_tag, e_tag); end
            n_cmp++; if (out_illegal !== e_ill) begin n_err++; $display("FAIL rnd_illegal c=%0d got=%b exp=%b", c, out_illegal, e_ill); end
            n_cmp++; if (illegal_cnt !== CNT_W'(mcnt)) begin n_err++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, illegal_cnt, mcnt); end
            @(posedge clk); #1;
            drive($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)), TAG_W'($urandom));
            out_ready = $urandom_range(0, 2) != 0;
            flush     = $urandom_range(0, 15) == 0;
        end
        drive(1'b0, '0, '0, '0);
        flush = 1'b0;
    endtask

    task automatic test_saturation;
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive(1'b1, $urandom, 3'b111, 8'h51);
        repeat (260) @(posedge clk);
        #1;
        drive(1'b0, '0, '0, '0);
        @(negedge clk);
        n_cmp++; if (illegal_cnt !== CNT_W'(CNT_MAX)) begin n_err++; $display("FAIL sat_cnt got=%0d exp=%0d", illegal_cnt, CNT_MAX); end
    endtask

    task automatic test_async_reset;
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(1'b1, $urandom, 3'b010, 8'h61);
        @(posedge clk); #2;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ar_pre_valid got=%b exp=1", out_valid); end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ar_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL ar_in_ready got=%b exp=0", in_ready); end
        n_cmp++; if (illegal_cnt !== '0) begin n_err++; $display("FAIL ar_cnt got=%0d exp=0", illegal_cnt); end
        n_cmp++; if (out_tag !== '0) begin n_err++; $display("FAIL ar_out_tag got=%h exp=0", out_tag); end
        drive(1'b0, '0, '0, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ar_release_ready got=%b exp=1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_i_format();
        test_back_to_back();
        test_u_format();
        test_backpressure();
        test_flush();
        test_random();
        test_saturation();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
